// File: rtl/adder_subtractor_16bit_overflow.sv
// Registered two's-complement adder/subtractor with carry, signed/unsigned overflow, zero and negative flags.
// Latency 1 cycle, one result per cycle, no backpressure; outputs hold when in_valid=0.
module adder_subtractor_16bit_overflow #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             signed_overflow,
  output logic             unsigned_overflow,
  output logic             zero_flag,
  output logic             negative_flag
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] eff_b;
  logic [WIDTH:0]   sum_d;
  logic             so_d;
  logic             uo_d;
  logic             z_d;

  logic             valid_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             so_q;
  logic             uo_q;
  logic             z_q;
  logic             n_q;

  // Subtraction reuses the adder: invert B and inject sub as carry-in.
  assign eff_b = b ^ {WIDTH{sub}};
  assign sum_d = {1'b0, a} + {1'b0, eff_b} + {{WIDTH{1'b0}}, sub};

  always_comb begin
    so_d = (a[MSB] == eff_b[MSB]) && (sum_d[MSB] != a[MSB]);
    uo_d = sum_d[WIDTH] ^ sub;
    z_d  = (sum_d[MSB:0] == '0);
  end

  // zero_flag resets to 0 even though result resets to 0: it tracks computed results only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
      so_q     <= 1'b0;
      uo_q     <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        result_q <= sum_d[MSB:0];
        carry_q  <= sum_d[WIDTH];
        so_q     <= so_d;
        uo_q     <= uo_d;
        z_q      <= z_d;
        n_q      <= sum_d[MSB];
      end
    end
  end

  assign out_valid         = valid_q;
  assign result            = result_q;
  assign carry_out         = carry_q;
  assign signed_overflow   = so_q;
  assign unsigned_overflow = uo_q;
  assign zero_flag         = z_q;
  assign negative_flag     = n_q;

endmodule

// File: tb/tb_adder_subtractor_16bit_overflow.sv
// Scoreboard bench: expected results queued at drive time, popped one cycle later and compared.
module tb_adder_subtractor_16bit_overflow;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        out_valid;
  logic [15:0] result;
  logic        carry_out;
  logic        signed_overflow;
  logic        unsigned_overflow;
  logic        zero_flag;
  logic        negative_flag;

  // flags packed as {C, SO, UO, Z, N}
  typedef struct packed {
    logic [15:0] res;
    logic [4:0]  flg;
  } exp_t;

  typedef struct packed {
    logic [15:0] va;
    logic [15:0] vb;
    logic        vsub;
    logic [15:0] vres;
    logic [4:0]  vflg;
  } vec_t;

  exp_t sb[$];
  exp_t last_exp;
  int   tests_run;
  int   tests_failed;

  adder_subtractor_16bit_overflow #(.WIDTH(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .a                 (a),
    .b                 (b),
    .sub               (sub),
    .out_valid         (out_valid),
    .result            (result),
    .carry_out         (carry_out),
    .signed_overflow   (signed_overflow),
    .unsigned_overflow (unsigned_overflow),
    .zero_flag         (zero_flag),
    .negative_flag     (negative_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model in integer arithmetic, independent of the adder formulation.
  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic s);
    exp_t m;
    int ua;
    int ub;
    int sa;
    int sbv;
    int ur;
    int sr;
    logic c;
    logic uo;
    ua  = int'(x);
    ub  = int'(y);
    sa  = int'($signed(x));
    sbv = int'($signed(y));
    if (!s) begin
      ur = ua + ub;
      sr = sa + sbv;
      c  = (ur > 65535);
      uo = c;
    end else begin
      ur = ua - ub;
      sr = sa - sbv;
      uo = (ua < ub);
      c  = !uo;
    end
    m.res = ur[15:0];
    m.flg = {c, (sr > 32767) || (sr < -32768), uo, (ur[15:0] == 16'h0), ur[15]};
    return m;
  endfunction

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    sub      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({out_valid, result, carry_out, signed_overflow, unsigned_overflow, zero_flag, negative_flag} !== 22'h0) begin
      tests_failed++;
      $display("FAIL reset_state: got v=%b r=%h f=%b%b%b%b%b, want all zero", out_valid, result,
               carry_out, signed_overflow, unsigned_overflow, zero_flag, negative_flag);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    vec_t tab[14];
    exp_t e;
    tab[0]  = {16'd100,   16'd200,   1'b0, 16'd300,   5'b00000};
    tab[1]  = {16'd0,     16'd0,     1'b0, 16'd0,     5'b00010};
    tab[2]  = {16'd300,   16'd100,   1'b1, 16'd200,   5'b10000};
    tab[3]  = {16'd100,   16'd100,   1'b1, 16'd0,     5'b10010};
    tab[4]  = {16'd0,     16'd1,     1'b1, 16'hFFFF,  5'b00101};
    tab[5]  = {16'hFFFF,  16'd1,     1'b0, 16'h0000,  5'b10110};
    tab[6]  = {16'h8000,  16'h8000,  1'b0, 16'h0000,  5'b11110};
    tab[7]  = {16'h7FFF,  16'd1,     1'b0, 16'h8000,  5'b01001};
    tab[8]  = {16'd20000, 16'd20000, 1'b0, 16'd40000, 5'b01001};
    tab[9]  = {16'h8000,  16'hFFFF,  1'b0, 16'h7FFF,  5'b11100};
    tab[10] = {16'hE000,  16'hE000,  1'b0, 16'hC000,  5'b10101};
    tab[11] = {16'h7FFF,  16'hFFFF,  1'b1, 16'h8000,  5'b01101};
    tab[12] = {16'h8000,  16'd1,     1'b1, 16'h7FFF,  5'b11000};
    tab[13] = {16'h7FFF,  16'd1,     1'b1, 16'h7FFE,  5'b10000};
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      a        = tab[i].va;
      b        = tab[i].vb;
      sub      = tab[i].vsub;
      in_valid = 1'b1;
      sb.push_back({tab[i].vres, tab[i].vflg});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      last_exp = e;
      tests_run++;
      if ({out_valid, result, carry_out, signed_overflow, unsigned_overflow, zero_flag, negative_flag}
          !== {1'b1, e.res, e.flg}) begin
        tests_failed++;
        $display("FAIL directed[%0d]: got v=%b r=%h CSOUZN=%b%b%b%b%b, want v=1 r=%h CSOUZN=%b", i,
                 out_valid, result, carry_out, signed_overflow, unsigned_overflow, zero_flag,
                 negative_flag, e.res, e.flg);
      end
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    in_valid = 1'b0;
    a        = 16'h1234;
    b        = 16'h4321;
    sub      = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if ({out_valid, result, carry_out, signed_overflow, unsigned_overflow, zero_flag, negative_flag}
          !== {1'b0, last_exp.res, last_exp.flg}) begin
        tests_failed++;
        $display("FAIL hold[%0d]: got v=%b r=%h CSOUZN=%b%b%b%b%b, want v=0 r=%h CSOUZN=%b", i,
                 out_valid, result, carry_out, signed_overflow, unsigned_overflow, zero_flag,
                 negative_flag, last_exp.res, last_exp.flg);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [15:0] va[3];
    logic [15:0] vb[3];
    logic        vs[3];
    va[0] = 16'd5;    vb[0] = 16'd7;    vs[0] = 1'b0;
    va[1] = 16'd7;    vb[1] = 16'd9;    vs[1] = 1'b1;
    va[2] = 16'hFFFE; vb[2] = 16'd2;    vs[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a        = va[i];
      b        = vb[i];
      sub      = vs[i];
      in_valid = 1'b1;
      sb.push_back(model(va[i], vb[i], vs[i]));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      last_exp = e;
      tests_run++;
      if ({out_valid, result, carry_out, signed_overflow, unsigned_overflow, zero_flag, negative_flag}
          !== {1'b1, e.res, e.flg}) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: got v=%b r=%h CSOUZN=%b%b%b%b%b, want v=1 r=%h CSOUZN=%b", i,
                 out_valid, result, carry_out, signed_overflow, unsigned_overflow, zero_flag,
                 negative_flag, e.res, e.flg);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    @(negedge clk);
    a        = 16'h7FFF;
    b        = 16'd1;
    sub      = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    a        = 16'h0003;
    b        = 16'h0004;
    rst      = 1'b1;
    #1;
    tests_run++;
    if ({out_valid, result, carry_out, signed_overflow, unsigned_overflow, zero_flag, negative_flag} !== 22'h0) begin
      tests_failed++;
      $display("FAIL async_reset_immediate: got v=%b r=%h f=%b%b%b%b%b, want all zero", out_valid, result,
               carry_out, signed_overflow, unsigned_overflow, zero_flag, negative_flag);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if ({out_valid, result, carry_out, signed_overflow, unsigned_overflow, zero_flag, negative_flag} !== 22'h0) begin
      tests_failed++;
      $display("FAIL async_reset_held: got v=%b r=%h f=%b%b%b%b%b, want all zero", out_valid, result,
               carry_out, signed_overflow, unsigned_overflow, zero_flag, negative_flag);
    end
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (out_valid !== 1'b0 || result !== 16'h0) begin
      tests_failed++;
      $display("FAIL post_reset_idle: got v=%b r=%h, want v=0 r=0000", out_valid, result);
    end
    @(negedge clk);
    a        = 16'h0003;
    b        = 16'h0004;
    sub      = 1'b1;
    in_valid = 1'b1;
    sb.push_back(model(16'h0003, 16'h0004, 1'b1));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    tests_run++;
    if ({out_valid, result, carry_out, signed_overflow, unsigned_overflow, zero_flag, negative_flag}
        !== {1'b1, e.res, e.flg}) begin
      tests_failed++;
      $display("FAIL post_reset_first: got v=%b r=%h CSOUZN=%b%b%b%b%b, want v=1 r=%h CSOUZN=%b",
               out_valid, result, carry_out, signed_overflow, unsigned_overflow, zero_flag,
               negative_flag, e.res, e.flg);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_random();
    exp_t e;
    logic [15:0] ra;
    logic [15:0] rb;
    logic        rs;
    int          bad;
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rs = 1'($urandom_range(0, 1));
      a        = ra;
      b        = rb;
      sub      = rs;
      in_valid = 1'b1;
      sb.push_back(model(ra, rb, rs));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      tests_run++;
      if ({out_valid, result, carry_out, signed_overflow, unsigned_overflow, zero_flag, negative_flag}
          !== {1'b1, e.res, e.flg}) begin
        tests_failed++;
        bad++;
        if (bad <= 10)
          $display("FAIL random[%0d] a=%h b=%h sub=%b: got v=%b r=%h CSOUZN=%b%b%b%b%b, want v=1 r=%h CSOUZN=%b",
                   i, ra, rb, rs, out_valid, result, carry_out, signed_overflow, unsigned_overflow,
                   zero_flag, negative_flag, e.res, e.flg);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    last_exp     = '0;
    test_reset();
    test_directed();
    test_hold();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
